// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: one request channel (in_*, op, a, b,
// kill) and one response channel (out_*, result, flags).
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and an unaccepted response holds steady.
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  kill;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, result, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, result, div_by_zero, overflow
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle (shift-add / restoring
// division) on magnitudes, sign fixed up in FIX; div-by-zero and overflow skip CALC.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_unit_if.slave      bus,
  output logic [1:0]        dbg_state_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     dvsr_q, dvsr_d;
  logic [W-1:0]     result_q, result_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;

  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, fast_dz, fast_ovf, take;
  logic [W-1:0]     a_mag, b_mag, div_src, div_fix;
  logic [W:0]       mul_sum, shifted;
  logic [2*W-1:0]   prod_fix;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    a_sgn    = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_sgn    = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg    = a_sgn && bus.a[W-1];
    b_neg    = b_sgn && bus.b[W-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    is_div   = bus.op[2];
    fast_dz  = is_div && (bus.b == '0);
    fast_ovf = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);

    // Multiply: low half holds the remaining multiplier bits, high half the sum.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? dvsr_q : {W{1'b0}})};
    // Divide: low half holds dividend bits shifting out and quotient bits shifting in.
    shifted  = {rem_q[W-1:0], acc_q[W-1]};
    take     = (shifted >= {1'b0, dvsr_q});

    prod_fix = neg_q ? -acc_q : acc_q;
    div_src  = op_q[1] ? rem_q[W-1:0] : acc_q[W-1:0];
    div_fix  = neg_q ? -div_src : div_src;

    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_d  = bus.op;
            cnt_d = '0;
            dz_d  = 1'b0;
            ovf_d = 1'b0;
            rem_d = '0;
            state_d = S_CALC;
            if (is_div) begin
              neg_d  = bus.op[1] ? a_neg : (a_neg ^ b_neg);
              acc_d  = {{W{1'b0}}, a_mag};
              dvsr_d = b_mag;
            end else begin
              neg_d  = a_neg ^ b_neg;
              acc_d  = {{W{1'b0}}, b_mag};
              dvsr_d = a_mag;
            end
            if (fast_dz) begin
              dz_d     = 1'b1;
              result_d = bus.op[1] ? bus.a : {W{1'b1}};
              state_d  = S_DONE;
            end else if (fast_ovf) begin
              ovf_d    = 1'b1;
              result_d = bus.op[1] ? {W{1'b0}} : bus.a;
              state_d  = S_DONE;
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], take};
            rem_d = take ? (shifted - {1'b0, dvsr_q}) : shifted;
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) state_d = S_FIX;
        end
        S_FIX: begin
          case (op_q)
            OP_MUL:                       result_d = prod_fix[W-1:0];
            3'd1, 3'd2, 3'd3:             result_d = prod_fix[2*W-1:W];
            default:                      result_d = div_fix;
          endcase
          state_d = S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      in_ready_q <= (state_d == S_IDLE);
    end
  end

  // in_ready is its own flop so it stays low through reset without a path from rst_n.
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, fast paths,
// backpressure, kill and mid-operation reset.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         vectors = 0;
  int         miscompares = 0;
  logic [W-1:0] exp_q[$];

  muldiv_unit_if #(.DATA_WIDTH(W)) bus();

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for in_ready, then holds the request across one rising edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen (0 = next cycle).
  task automatic wait_out(output int edges);
    edges = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expv,
                       input logic dz, input logic ovf, input int lat);
    int edges;
    logic [W-1:0] e;
    exp_q.push_back(expv);
    send(op, a, b);
    wait_out(edges);
    e = exp_q.pop_front();
    check({tag, "_lat"}, W'(edges), W'(lat));
    check({tag, "_res"}, bus.result, e);
    check({tag, "_dz"}, W'(bus.div_by_zero), W'(dz));
    check({tag, "_ovf"}, W'(bus.overflow), W'(ovf));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld_drop"}, W'(bus.out_valid), '0);
    check({tag, "_rdy_back"}, W'(bus.in_ready), W'(1));
  endtask

  initial begin
    int edges;
    int seen;
    logic [W-1:0] e;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.kill = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), '0);
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_result", bus.result, '0);
    check("rst_dz", W'(bus.div_by_zero), '0);
    check("rst_ovf", W'(bus.overflow), '0);
    check("rst_state", W'(dbg_state), '0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready", W'(bus.in_ready), W'(1));

    do_op("mul_small", MUL, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 0, 0, 33);
    do_op("mulh_m1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 33);
    do_op("mulhu_m1", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 33);
    do_op("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33);
    do_op("mul_m1", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 33);
    do_op("div_neg", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, 0, 33);
    do_op("rem_neg", REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, 0, 33);
    do_op("div_negb", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 33);
    do_op("rem_negb", REM, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 33);
    do_op("div_min2", DIV, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 0, 0, 33);
    do_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 0, 0, 33);
    do_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 0, 0, 33);
    do_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 33);
    do_op("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    do_op("remu_by0", REMU, 32'd5, 32'd0, 32'd5, 1, 0, 0);
    do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0);
    do_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 0);
    do_op("mul_after_flag", MUL, 32'd3, 32'd7, 32'd21, 0, 0, 33);

    // Backpressure: result held, in_ready low, stray requests ignored.
    bus.out_ready = 1'b0;
    exp_q.push_back(32'd14);
    send(DIVU, 32'd100, 32'd7);
    wait_out(edges);
    check("bp_lat", W'(edges), W'(33));
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.op = MUL;
      bus.a = 32'd3;
      bus.b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      check("bp_result", bus.result, e);
      check("bp_in_ready", W'(bus.in_ready), '0);
      check("bp_out_valid", W'(bus.out_valid), W'(1));
      check("bp_dz", W'(bus.div_by_zero), '0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_vld", W'(bus.out_valid), '0);
    check("bp_release_rdy", W'(bus.in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    check("bp_single_xfer", W'(bus.out_valid), '0);
    check("bp_idle", W'(dbg_state), '0);

    // kill with in_valid in IDLE must not accept.
    bus.in_valid = 1'b1;
    bus.kill = 1'b1;
    bus.op = MUL;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    @(negedge clk);
    check("kill_idle_state", W'(dbg_state), '0);
    check("kill_idle_rdy", W'(bus.in_ready), W'(1));

    // kill on the edge that would perform CALC step 10.
    send(MUL, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    @(negedge clk);
    check("kill_rdy", W'(bus.in_ready), W'(1));
    check("kill_vld", W'(bus.out_valid), '0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("kill_no_result", W'(seen), '0);
    do_op("mulhu_after_kill", MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 0, 33);

    // Reset in the middle of CALC.
    send(MUL, 32'd5, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_result", bus.result, '0);
    check("mrst_out_valid", W'(bus.out_valid), '0);
    check("mrst_in_ready", W'(bus.in_ready), '0);
    check("mrst_state", W'(dbg_state), '0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_rel_rdy", W'(bus.in_ready), W'(1));

    // Reset while a flagged result is held in DONE.
    bus.out_ready = 1'b0;
    send(DIV, 32'd5, 32'd0);
    wait_out(edges);
    check("drst_pre_dz", W'(bus.div_by_zero), W'(1));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drst_dz", W'(bus.div_by_zero), '0);
    check("drst_result", bus.result, '0);
    check("drst_out_valid", W'(bus.out_valid), '0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
